// File: rtl/debug_dump_sequencer_pkg.sv
// Shared select codes, EoD payload and sequencer state encoding for the debug dump path.
// Also used by the MicroBlaze interface and the MIPS debug read mux.
package debug_dump_sequencer_pkg;

  localparam logic [5:0] SEL_PC         = 6'b100010;
  localparam logic [5:0] SEL_MEM_DATA   = 6'b100000;
  localparam logic [5:0] SEL_MEM_INSTR  = 6'b100001;
  localparam logic [5:0] SEL_FETCH_DATA = 6'b100100;
  localparam logic [5:0] SEL_FETCH_CTRL = 6'b100101;
  localparam logic [5:0] SEL_DECO_DATA  = 6'b100110;
  localparam logic [5:0] SEL_DECO_CTRL  = 6'b100111;
  localparam logic [5:0] SEL_EXEC_DATA  = 6'b101000;
  localparam logic [5:0] SEL_EXEC_CTRL  = 6'b101001;
  localparam logic [5:0] SEL_MEM_LDATA  = 6'b101010;
  localparam logic [5:0] SEL_MEM_LCTRL  = 6'b101011;
  localparam logic [5:0] SEL_IDLE       = 6'b111111;

  localparam logic [31:0] EOD_PATTERN = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CAPTURE,
    ST_PRESENT,
    ST_SEND_EOD
  } dump_state_t;

endpackage

// File: rtl/debug_dump_sequencer_len_lut.sv
// Maps a group select code to {accepted, last word index} of the group.
module debug_group_len_lut
  import debug_dump_sequencer_pkg::*;
#(
  parameter int unsigned NB_SELECT   = 6,
  parameter int unsigned NB_WORD_IDX = 4,
  parameter int unsigned STRIP_WORDS = 16
) (
  input  logic [NB_SELECT-1:0]   i_select,
  output logic                   o_valid,
  output logic [NB_WORD_IDX-1:0] o_last_idx
);

  always_comb begin
    o_valid    = 1'b1;
    o_last_idx = NB_WORD_IDX'(STRIP_WORDS - 1);
    if (i_select == NB_SELECT'(SEL_IDLE)) begin
      o_valid    = 1'b0;
      o_last_idx = '0;
    end else if (!i_select[NB_SELECT-1] || i_select == NB_SELECT'(SEL_PC)) begin
      o_last_idx = '0;
    end
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams one debug group from the MIPS debug mux to the MicroBlaze, word by word,
// closing every transfer with an EoD frame.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int unsigned NB_CONTROL_FRAME = 32,
  parameter int unsigned NB_SELECT        = 6,
  parameter int unsigned NB_WORD_IDX      = 4,
  parameter int unsigned STRIP_WORDS      = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_req_valid,
  input  logic [NB_SELECT-1:0]        i_req_select,
  output logic                        o_req_ready,
  output logic [NB_SELECT-1:0]        o_mips_select,
  output logic [NB_WORD_IDX-1:0]      o_word_idx,
  input  logic [NB_CONTROL_FRAME-1:0] i_mips_data,
  output logic [NB_CONTROL_FRAME-1:0] o_frame,
  output logic                        o_frame_valid,
  input  logic                        i_frame_ack,
  output logic                        o_eod,
  output logic                        o_busy
);

  dump_state_t                 state_q, state_d;
  logic [NB_SELECT-1:0]        sel_q, sel_d;
  logic [NB_WORD_IDX-1:0]      last_q, last_d;
  logic [NB_WORD_IDX-1:0]      idx_q, idx_d;
  logic [NB_CONTROL_FRAME-1:0] frame_q, frame_d;
  logic                        valid_q, valid_d;
  logic                        eod_q, eod_d;
  logic                        ready_q, ready_d;

  logic                        lut_valid;
  logic [NB_WORD_IDX-1:0]      lut_last;

  debug_group_len_lut #(
    .NB_SELECT   (NB_SELECT),
    .NB_WORD_IDX (NB_WORD_IDX),
    .STRIP_WORDS (STRIP_WORDS)
  ) u_len_lut (
    .i_select   (i_req_select),
    .o_valid    (lut_valid),
    .o_last_idx (lut_last)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      sel_q   <= NB_SELECT'(SEL_IDLE);
      last_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      eod_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      eod_q   <= eod_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (i_req_valid) state_d = lut_valid ? ST_SETUP : ST_SEND_EOD;
      ST_SETUP:    state_d = ST_CAPTURE;
      ST_CAPTURE:  state_d = ST_PRESENT;
      ST_PRESENT:  if (i_frame_ack) state_d = (idx_q == last_q) ? ST_SEND_EOD : ST_SETUP;
      ST_SEND_EOD: if (valid_q && i_frame_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // EoD is raised one cycle after entering SEND_EOD so valid drops between the
  // last data word and the marker, keeping o_frame stable for every valid frame.
  always_comb begin
    sel_d   = sel_q;
    last_d  = last_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    valid_d = valid_q;
    eod_d   = eod_q;
    ready_d = ready_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          sel_d   = i_req_select;
          last_d  = lut_last;
          idx_d   = '0;
          ready_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        frame_d = i_mips_data;
        valid_d = 1'b1;
      end
      ST_PRESENT: begin
        if (i_frame_ack) begin
          valid_d = 1'b0;
          if (idx_q != last_q) idx_d = idx_q + NB_WORD_IDX'(1);
        end
      end
      ST_SEND_EOD: begin
        if (!valid_q) begin
          frame_d = NB_CONTROL_FRAME'(EOD_PATTERN);
          eod_d   = 1'b1;
          valid_d = 1'b1;
        end else if (i_frame_ack) begin
          frame_d = '0;
          eod_d   = 1'b0;
          valid_d = 1'b0;
          sel_d   = NB_SELECT'(SEL_IDLE);
          idx_d   = '0;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_req_ready   = ready_q;
  assign o_busy        = ~ready_q;
  assign o_mips_select = sel_q;
  assign o_word_idx    = idx_q;
  assign o_frame       = frame_q;
  assign o_frame_valid = valid_q;
  assign o_eod         = eod_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench: requests push expected frames, a negedge monitor pops on each handshake.
module tb_debug_dump_sequencer;

  typedef struct {
    logic [31:0] data;
    logic        eod;
  } exp_t;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [5:0]  i_req_select = '0;
  logic        i_frame_ack = 1'b0;
  logic [31:0] i_mips_data;
  logic        o_req_ready, o_frame_valid, o_eod, o_busy;
  logic [5:0]  o_mips_select;
  logic [3:0]  o_word_idx;
  logic [31:0] o_frame;

  logic [31:0] tbl [64][16];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_mode = 0;
  int          ack_wait = 0;

  debug_dump_sequencer #(
    .NB_CONTROL_FRAME (32),
    .NB_SELECT        (6),
    .NB_WORD_IDX      (4),
    .STRIP_WORDS      (16)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_req_valid   (i_req_valid),
    .i_req_select  (i_req_select),
    .o_req_ready   (o_req_ready),
    .o_mips_select (o_mips_select),
    .o_word_idx    (o_word_idx),
    .i_mips_data   (i_mips_data),
    .o_frame       (o_frame),
    .o_frame_valid (o_frame_valid),
    .i_frame_ack   (i_frame_ack),
    .o_eod         (o_eod),
    .o_busy        (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Debug mux model: combinational lookup by select/index
  always_comb i_mips_data = tbl[o_mips_select][o_word_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int group_len(input logic [5:0] sel);
    if (sel == 6'h3F) return 0;
    if (sel < 6'd32 || sel == 6'b100010) return 1;
    return 16;
  endfunction

  task automatic push_expected(input logic [5:0] sel);
    exp_t e;
    for (int i = 0; i < group_len(sel); i++) begin
      e.data = tbl[sel][i];
      e.eod  = 1'b0;
      sb.push_back(e);
    end
    e.data = 32'hFFFF_FFFF;
    e.eod  = 1'b1;
    sb.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
    chk({tag, "_mips_select"}, {26'd0, o_mips_select}, 32'h3F);
    chk({tag, "_word_idx"}, {28'd0, o_word_idx}, 32'd0);
    chk({tag, "_frame"}, o_frame, 32'd0);
    chk({tag, "_frame_valid"}, {31'd0, o_frame_valid}, 32'd0);
    chk({tag, "_eod"}, {31'd0, o_eod}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic do_req(input logic [5:0] sel, input bit measure);
    bit ok;
    int cyc;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clock);
      if (o_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    i_req_select = sel;
    i_req_valid  = 1'b1;
    push_expected(sel);
    @(posedge i_clock);
    #1;
    i_req_valid = 1'b0;
    chk("accept_ready_low", {31'd0, o_req_ready}, 32'd0);
    if (measure) begin
      cyc = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge i_clock);
        #1;
        cyc++;
        if (o_frame_valid) break;
      end
      chk("accept_latency", cyc, (sel == 6'h3F) ? 32'd1 : 32'd2);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clock);
      if (o_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Ack driver: 0 = always high, 1 = hold each frame 5 cycles, other = random
  initial forever begin
    @(posedge i_clock);
    #1;
    case (ack_mode)
      0: i_frame_ack = 1'b1;
      1: begin
        if (o_frame_valid) begin
          ack_wait++;
          i_frame_ack = (ack_wait > 5);
        end else begin
          ack_wait    = 0;
          i_frame_ack = 1'b0;
        end
      end
      default: i_frame_ack = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: stability while valid, busy/ready relation, pop on handshake
  initial begin
    logic [31:0] held;
    bit          holding;
    exp_t        e;
    holding = 1'b0;
    held    = '0;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        holding = 1'b0;
      end else begin
        chk("busy_is_not_ready", {31'd0, o_busy}, {31'd0, ~o_req_ready});
        if (o_frame_valid) begin
          if (holding) chk("frame_stable", o_frame, held);
          held    = o_frame;
          holding = 1'b1;
          if (i_frame_ack) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_frame: got %h eod=%0d, required no frame", o_frame, o_eod);
            end else begin
              e = sb.pop_front();
              chk("frame_data", o_frame, e.data);
              chk("frame_eod", {31'd0, o_eod}, {31'd0, e.eod});
            end
            holding = 1'b0;
          end
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] sel;
    int         r;
    bit         ok;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 16; j++) tbl[i][j] = $urandom;
    tbl[5][0] = 32'hDEAD_BEEF;
    for (int j = 0; j < 16; j++) tbl[36][j] = 32'hA000_0000 + 32'(j);

    repeat (2) @(posedge i_clock);
    #1;
    check_reset_values("reset");
    i_reset = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    check_reset_values("idle");

    ack_mode = 0;
    do_req(6'b000101, 1'b1);
    wait_idle();
    do_req(6'b100100, 1'b1);
    wait_idle();

    ack_mode = 1;
    do_req(6'b100100, 1'b0);
    wait_idle();

    ack_mode = 0;
    do_req(6'h3F, 1'b1);
    wait_idle();

    // Requests while busy must be dropped
    ack_mode = 1;
    do_req(6'b100100, 1'b0);
    i_req_select = 6'b000101;
    i_req_valid  = 1'b1;
    repeat (5) @(posedge i_clock);
    #1;
    i_req_valid = 1'b0;
    wait_idle();
    repeat (4) @(negedge i_clock);
    chk("sb_empty_after_busy_req", sb.size(), 32'd0);

    // Reset at word 7 of a strip
    ack_mode = 1;
    do_req(6'b100100, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge i_clock);
      if (o_frame_valid && o_word_idx == 4'd7) begin ok = 1'b1; break; end
    end
    if (!ok) chk("word7_timeout", 32'd0, 32'd1);
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    check_reset_values("midreset");
    sb.delete();
    i_reset = 1'b0;
    repeat (10) @(negedge i_clock);
    chk("no_eod_after_reset", {31'd0, o_frame_valid}, 32'd0);
    ack_mode = 0;
    do_req(6'b100100, 1'b1);
    wait_idle();

    // Randomized traffic
    ack_mode = 2;
    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      sel = 6'h3F;
      else if (r < 4)  sel = 6'($urandom_range(0, 31));
      else if (r == 4) sel = 6'b100010;
      else             sel = 6'($urandom_range(32, 62));
      for (int j = 0; j < 16; j++) tbl[sel][j] = $urandom;
      do_req(sel, 1'b0);
      wait_idle();
    end

    repeat (5) @(negedge i_clock);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
